// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared flag positions, flag typedefs and arbiter state enum
package stream_pkg;
    localparam int MF_A = 3;
    localparam int MF_F = 2;
    localparam int MF_L = 1;
    localparam int MF_V = 0;
    localparam int SF_BUSY = 0;

    typedef logic [3:0] mflags_t;
    typedef logic [1:0] sflags_t;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;
endpackage

// File: rtl/csc_stream_arb_if.sv
// rtl/csc_stream_arb_if.sv - requester-side and csc-side stream bundle of the arbiter
interface csc_stream_arb_if #(
    parameter int W  = 16,
    parameter int N  = 4,
    parameter int TW = $clog2(N)
) ();
    import stream_pkg::*;

    logic [N*W-1:0] uc_d0;
    logic [N*W-1:0] uc_d1;
    logic [N*W-1:0] uc_d2;
    logic [N*4-1:0] uc_mflags;
    logic [N*2-1:0] cu_sflags;
    logic [W-1:0]   cd_d0;
    logic [W-1:0]   cd_d1;
    logic [W-1:0]   cd_d2;
    mflags_t        cd_mflags;
    logic [TW-1:0]  cd_tag;
    sflags_t        dc_sflags;

    modport master (
        output uc_d0, uc_d1, uc_d2, uc_mflags, dc_sflags,
        input  cu_sflags, cd_d0, cd_d1, cd_d2, cd_mflags, cd_tag
    );

    modport slave (
        input  uc_d0, uc_d1, uc_d2, uc_mflags, dc_sflags,
        output cu_sflags, cd_d0, cd_d1, cd_d2, cd_mflags, cd_tag
    );
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin first-one finder starting at ptr
module rr_pick #(
    parameter int N  = 4,
    parameter int TW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [TW-1:0] ptr,
    output logic          valid,
    output logic [TW-1:0] idx
);
    logic [N-1:0] rot;
    logic [TW:0]  sum;

    // Rotate so bit 0 is the requester at ptr; the lowest set bit wins.
    always_comb begin
        rot   = N'({req, req} >> ptr);
        valid = |req;
        idx   = '0;
        sum   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr} + (TW+1)'(k);
                if (sum >= (TW+1)'(N)) begin
                    sum = sum - (TW+1)'(N);
                end
                idx = sum[TW-1:0];
            end
        end
    end
endmodule

// File: rtl/csc_stream_arb.sv
// rtl/csc_stream_arb.sv - packet-granular round-robin arbiter in front of the csc datapath
module csc_stream_arb
    import stream_pkg::*;
#(
    parameter int W  = 16,
    parameter int N  = 4,
    parameter int TW = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          cfg_en,
    csc_stream_arb_if.slave       bus,
    output logic                  err_orphan
);
    arb_state_t     state;
    logic [TW-1:0]  grant;
    logic [TW-1:0]  rr_ptr;
    logic [TW-1:0]  grant_next;

    logic [N-1:0]   req_vec;
    logic [N-1:0]   orphan_sel;
    logic [N-1:0]   busy;
    logic [2*N-1:0] sflags_v;
    logic           pick_valid;
    logic [TW-1:0]  pick_idx;

    mflags_t        g_mf;
    logic [W-1:0]   g_d0;
    logic [W-1:0]   g_d1;
    logic [W-1:0]   g_d2;
    logic           locked;
    logic           load_en;
    logic           g_xfer;
    logic           orphan_hit;
    logic           unused_sflag;

    assign unused_sflag = bus.dc_sflags[1];

    rr_pick #(.N(N), .TW(TW)) u_pick (
        .req   (req_vec),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        locked     = (state == LOCK);
        load_en    = !bus.cd_mflags[MF_V] || !bus.dc_sflags[SF_BUSY];
        grant_next = (grant == TW'(N - 1)) ? '0 : grant + 1'b1;
        g_mf       = '0;
        g_d0       = '0;
        g_d1       = '0;
        g_d2       = '0;
        req_vec    = '0;
        orphan_sel = '0;
        busy       = '1;
        sflags_v   = '0;
        for (int i = 0; i < N; i++) begin
            req_vec[i] = cfg_en[i] & bus.uc_mflags[i*4 + MF_V] & bus.uc_mflags[i*4 + MF_F];
            if (grant == TW'(i)) begin
                g_mf = bus.uc_mflags[i*4 +: 4];
                g_d0 = bus.uc_d0[i*W +: W];
                g_d1 = bus.uc_d1[i*W +: W];
                g_d2 = bus.uc_d2[i*W +: W];
            end
        end
        // Headless beats from anyone but the lock owner are dropped, lowest index first.
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.uc_mflags[i*4 + MF_V] && !bus.uc_mflags[i*4 + MF_F]
                && !(locked && grant == TW'(i))) begin
                orphan_sel    = '0;
                orphan_sel[i] = 1'b1;
            end
        end
        orphan_hit = |orphan_sel;
        g_xfer     = locked && g_mf[MF_V] && load_en;
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                busy[i] = 1'b1;
            end else if (orphan_sel[i]) begin
                busy[i] = 1'b0;
            end else if (locked && grant == TW'(i)) begin
                busy[i] = !load_en;
            end
            sflags_v[i*2 + SF_BUSY] = busy[i];
        end
    end

    assign bus.cu_sflags = sflags_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant         <= '0;
            rr_ptr        <= '0;
            err_orphan    <= 1'b0;
            bus.cd_d0     <= '0;
            bus.cd_d1     <= '0;
            bus.cd_d2     <= '0;
            bus.cd_mflags <= '0;
            bus.cd_tag    <= '0;
        end else begin
            err_orphan <= orphan_hit;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant <= pick_idx;
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    if (g_xfer && g_mf[MF_L]) begin
                        rr_ptr <= grant_next;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (load_en) begin
                if (g_xfer) begin
                    bus.cd_d0           <= g_d0;
                    bus.cd_d1           <= g_d1;
                    bus.cd_d2           <= g_d2;
                    bus.cd_tag          <= grant;
                    bus.cd_mflags[MF_A] <= g_mf[MF_A];
                    bus.cd_mflags[MF_F] <= g_mf[MF_F];
                    bus.cd_mflags[MF_L] <= g_mf[MF_L];
                    bus.cd_mflags[MF_V] <= 1'b1;
                end else begin
                    bus.cd_mflags <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_csc_stream_arb.sv
// tb/tb_csc_stream_arb.sv - directed vector bench for csc_stream_arb
module tb_csc_stream_arb;
    import stream_pkg::*;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int TW = 2;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] cfg_en;
    logic         err_orphan;

    csc_stream_arb_if #(.W(W), .N(N), .TW(TW)) bus ();

    csc_stream_arb #(.W(W), .N(N), .TW(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_en     (cfg_en),
        .bus        (bus),
        .err_orphan (err_orphan)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dc;
        logic [3:0]  ef;
        logic [15:0] ed;
        logic        eb0;
    } vec_t;

    vec_t        tbl [17];
    int          errors = 0;
    int          checks = 0;
    int          cyc;
    logic [15:0] bd [N][16];
    logic [3:0]  bf [N][16];
    int          hd [N];
    int          cnt [N];
    logic [N-1:0] acc;
    int          mon_n;
    logic [TW-1:0] mon_tag [64];
    logic [15:0] mon_d [64];
    int          orphan_pulses;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (hd[i] < cnt[i]) begin
                bus.uc_d0[i*W +: W]   = bd[i][hd[i]];
                bus.uc_d1[i*W +: W]   = bd[i][hd[i]] + 16'h100;
                bus.uc_d2[i*W +: W]   = bd[i][hd[i]] + 16'h200;
                bus.uc_mflags[i*4 +: 4] = bf[i][hd[i]];
            end else begin
                bus.uc_d0[i*W +: W]   = '0;
                bus.uc_d1[i*W +: W]   = '0;
                bus.uc_d2[i*W +: W]   = '0;
                bus.uc_mflags[i*4 +: 4] = 4'h0;
            end
        end
    endtask

    task automatic push(input int r, input logic [15:0] d, input logic [3:0] f);
        bd[r][cnt[r]] = d;
        bf[r][cnt[r]] = f;
        cnt[r]++;
    endtask

    // Sample handshakes at the negedge, pop accepted heads after the posedge.
    task automatic advance();
        for (int i = 0; i < N; i++) acc[i] = bus.uc_mflags[i*4 + MF_V] & !bus.cu_sflags[i*2];
        if (bus.cd_mflags[MF_V] && !bus.dc_sflags[SF_BUSY]) begin
            mon_tag[mon_n] = bus.cd_tag;
            mon_d[mon_n]   = bus.cd_d0;
            mon_n++;
        end
        if (err_orphan) orphan_pulses++;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc[i]) hd[i]++;
        drive();
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            hd[i]  = 0;
            cnt[i] = 0;
        end
        drive();
        bus.dc_sflags = 2'b00;
        cfg_en = 4'hF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        mon_n = 0;
        orphan_pulses = 0;
    endtask

    initial begin
        int p;
        int pos;
        int r;
        logic [15:0] ed;
        logic [3:0]  ef;

        tbl[0]  = '{1'b0, 4'h0, 16'd0, 1'b1};
        tbl[1]  = '{1'b0, 4'h0, 16'd0, 1'b0};
        tbl[2]  = '{1'b0, 4'h5, 16'd1, 1'b0};
        tbl[3]  = '{1'b0, 4'h9, 16'd2, 1'b0};
        tbl[4]  = '{1'b0, 4'h1, 16'd3, 1'b0};
        tbl[5]  = '{1'b0, 4'h1, 16'd4, 1'b0};
        tbl[6]  = '{1'b0, 4'h3, 16'd5, 1'b1};
        tbl[7]  = '{1'b0, 4'h0, 16'd5, 1'b0};
        tbl[8]  = '{1'b0, 4'h5, 16'd6, 1'b0};
        tbl[9]  = '{1'b1, 4'h1, 16'd7, 1'b1};
        tbl[10] = '{1'b1, 4'h1, 16'd7, 1'b1};
        tbl[11] = '{1'b1, 4'h1, 16'd7, 1'b1};
        tbl[12] = '{1'b1, 4'h1, 16'd7, 1'b1};
        tbl[13] = '{1'b0, 4'h1, 16'd7, 1'b0};
        tbl[14] = '{1'b0, 4'h1, 16'd8, 1'b0};
        tbl[15] = '{1'b0, 4'h3, 16'd9, 1'b1};
        tbl[16] = '{1'b0, 4'h0, 16'd9, 1'b1};

        // Reset values, both while held and just after release.
        cyc = 0;
        do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_sflags", bus.cu_sflags, 8'h55);
        chk("rst_mflags", bus.cd_mflags, 4'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_data", {bus.cd_d0, bus.cd_d1}, 32'h0);
        chk("rst_tag", bus.cd_tag, 2'd0);
        chk("rst_orphan", err_orphan, 1'b0);

        // Requester 0: 5-beat packet, 4-beat packet with a 4-cycle stall mid-packet.
        do_reset();
        push(0, 16'd1, 4'h5); push(0, 16'd2, 4'h9); push(0, 16'd3, 4'h1);
        push(0, 16'd4, 4'h1); push(0, 16'd5, 4'h3); push(0, 16'd6, 4'h5);
        push(0, 16'd7, 4'h1); push(0, 16'd8, 4'h1); push(0, 16'd9, 4'h3);
        drive();
        for (int c = 0; c < 17; c++) begin
            bus.dc_sflags = {1'b0, tbl[c].dc};
            #1;
            chk("t_flags", bus.cd_mflags, tbl[c].ef);
            chk("t_d0", bus.cd_d0, tbl[c].ed);
            chk("t_tag", bus.cd_tag, 2'd0);
            chk("t_busy0", bus.cu_sflags[0], tbl[c].eb0);
            if (tbl[c].ef[MF_V])
                chk("t_d12", {bus.cd_d1, bus.cd_d2}, {tbl[c].ed + 16'h100, tbl[c].ed + 16'h200});
            advance();
        end
        chk("t_beats", mon_n, 9);
        for (int k = 0; k < 9; k++) chk("t_stream", mon_d[k], 16'(k + 1));

        // Four simultaneous 3-beat packets: tags 0..3, one idle output cycle between.
        do_reset();
        for (int i = 0; i < N; i++) begin
            push(i, 16'(16*(i+1)),     4'h5);
            push(i, 16'(16*(i+1) + 1), 4'h1);
            push(i, 16'(16*(i+1) + 2), 4'h3);
        end
        drive();
        for (int c = 0; c < 18; c++) begin
            #1;
            if (c < 2) begin
                chk("rr_lead", bus.cd_mflags, 4'h0);
            end else begin
                p   = (c - 2) / 4;
                pos = (c - 2) % 4;
                ef  = (pos == 3) ? 4'h0 : (pos == 0) ? 4'h5 : (pos == 2) ? 4'h3 : 4'h1;
                chk("rr_flags", bus.cd_mflags, ef);
                if (pos != 3) chk("rr_beat", {bus.cd_tag, bus.cd_d0}, {2'(p), 16'(16*(p+1) + pos)});
            end
            if (c == 2) chk("rr_busy_waiting", bus.cu_sflags[7:2], 6'b010101);
            advance();
        end

        // Orphan beat from requester 2 while requester 1 holds the lock.
        do_reset();
        for (int k = 0; k < 4; k++) push(1, 16'(16'hA0 + k), (k == 0) ? 4'h5 : (k == 3) ? 4'h3 : 4'h1);
        drive();
        for (int c = 0; c < 8; c++) begin
            if (c == 3) begin
                push(2, 16'hBEEF, 4'h1);
                drive();
            end
            #1;
            if (c == 3) begin
                chk("orph_busy2", bus.cu_sflags[4], 1'b0);
                chk("orph_early", err_orphan, 1'b0);
            end
            if (c == 4) chk("orph_pulse", err_orphan, 1'b1);
            if (c == 5) chk("orph_end", err_orphan, 1'b0);
            if (c >= 2 && c <= 5) chk("orph_r1", {bus.cd_tag, bus.cd_d0}, {2'd1, 16'(16'hA0 + c - 2)});
            advance();
        end
        chk("orph_count", orphan_pulses, 1);
        chk("orph_consumed", hd[2], 1);
        chk("orph_beats", mon_n, 4);

        // Disable requester 0 mid-packet: it finishes, then is never granted again.
        do_reset();
        push(0, 16'hC0, 4'h5); push(0, 16'hC1, 4'h1); push(0, 16'hC2, 4'h1); push(0, 16'hC3, 4'h3);
        push(0, 16'hC4, 4'h5); push(0, 16'hC5, 4'h3);
        for (int i = 1; i < N; i++) begin
            push(i, 16'(16*(i+1)),     4'h5);
            push(i, 16'(16*(i+1) + 1), 4'h1);
            push(i, 16'(16*(i+1) + 2), 4'h3);
        end
        drive();
        for (int c = 0; c < 30; c++) begin
            if (c == 2) cfg_en = 4'b1110;
            #1;
            advance();
        end
        chk("en_beats", mon_n, 13);
        for (int k = 0; k < 13; k++) begin
            if (k < 4) begin
                r  = 0;
                ed = 16'(16'hC0 + k);
            end else begin
                r  = (k - 4) / 3 + 1;
                ed = 16'(16*(r+1) + (k - 4) % 3);
            end
            chk("en_stream", {mon_tag[k], mon_d[k]}, {2'(r), ed});
        end
        chk("en_r0_left", hd[0], 4);

        // All requesters disabled: no grant, orphans still drained.
        do_reset();
        cfg_en = 4'b0000;
        push(1, 16'h77, 4'h5);
        push(0, 16'h66, 4'h1);
        drive();
        for (int c = 0; c < 5; c++) begin
            #1;
            advance();
        end
        chk("dis_beats", mon_n, 0);
        chk("dis_orphan", orphan_pulses, 1);
        chk("dis_heads", {hd[0], hd[1]}, {32'd1, 32'd0});

        // Reset in the middle of a packet, then a fresh packet from requester 3.
        do_reset();
        for (int k = 0; k < 5; k++) push(0, 16'(16'hD1 + k), (k == 0) ? 4'h5 : (k == 4) ? 4'h3 : 4'h1);
        drive();
        for (int c = 0; c < 4; c++) begin
            #1;
            advance();
        end
        #1;
        chk("mid_beat3", bus.cd_d0, 16'hD3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flags", bus.cd_mflags, 4'h0);
        chk("mid_rst_busy", bus.cu_sflags, 8'h55);
        do_reset();
        push(3, 16'hE0, 4'h5);
        push(3, 16'hE1, 4'h3);
        drive();
        for (int c = 0; c < 6; c++) begin
            #1;
            if (c == 2) chk("mid_first", {bus.cd_tag, bus.cd_d0, bus.cd_mflags}, {2'd3, 16'hE0, 4'h5});
            advance();
        end
        chk("mid_beats", mon_n, 2);
        chk("mid_last", {mon_tag[1], mon_d[1]}, {2'd3, 16'hE1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/csc_stream_arb.md
# csc_stream_arb

Packet-granular round-robin arbiter sharing one `csc` colour-space-conversion datapath between `N` three-component requester streams, each a `gen_seq`-style source. Sits directly upstream of `csc`: selects one requester and locks onto it from its F beat to its L beat. Forwards the selected `d0/d1/d2` beats through one output register and applies per-requester backpressure via `sflags`. Tags every output beat with the requester index, so downstream logic can demultiplex `csc` results.

## Interface
- `W`, 16, component data width
- `N`, 4, number of requesters (2..8)
- `TW`, `$clog2(N)`, tag width
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `cfg_en`  in  N  requester enable mask; affects new grants only
- `uc_d0`, `uc_d1`, `uc_d2`  in  N*W each  requester components, requester i at `[i*W +: W]`
- `uc_mflags`  in  N*4  requester flags {A,F,L,V}, requester i at `[i*4 +: 4]`
- `cu_sflags`  out  N*2  to requesters, `[i*2]` = busy, `[i*2+1]` = 0
- `cd_d0`, `cd_d1`, `cd_d2`  out  W each  to `csc` `x0/x1/x2`
- `cd_mflags`  out  4  {A,F,L,V} of output beat
- `cd_tag`  out  TW  requester index of output beat
- `dc_sflags`  in  2  from `csc`, bit0 = busy, bit1 ignored
- `err_orphan`  out  1  one-cycle pulse: non-F beat from an unlocked requester was discarded

## Operation
- Beat transfer from requester i: `uc_mflags[i].V` & !`cu_sflags[i*2]`.
- FSM states:
  - IDLE: scan enabled requesters whose head beat has V&F, starting at `rr_ptr`, then `rr_ptr+1` mod N, and so on. If one is found, register `grant` and go to LOCK; the beat itself is not consumed this cycle. Otherwise stay in IDLE.
  - LOCK: forward beats from `grant` only. On transfer of a beat with L, set `rr_ptr` to `(grant+1)` mod N and go to IDLE.
- In LOCK, a beat carrying F (re-start) is forwarded unchanged; it does not restart arbitration.
- Orphan rule: while any requester is not granted, a V beat without F at its head is consumed and discarded. Its busy is held 0 for that cycle and `err_orphan` pulses. Only one pulse per cycle; the lowest index is consumed first.
- Non-granted requesters presenting V&F see busy=1.
- A (attribute) bit is passed through unmodified.
- Output register is loaded when it is empty or when `dc_sflags[0]`=0.
- Busy for the granted requester = output valid & `dc_sflags[0]`, or state≠LOCK.
- `cfg_en` cleared for the locked requester mid-packet: the lock is held until its L beat.
- All `N` requesters disabled: stay in IDLE; orphans are still discarded.

## Timing
- Reset values:
  - `cd_mflags`=0, `cd_d*`=0, `cd_tag`=0.
  - `cu_sflags` busy=1 for all i.
  - `err_orphan`=0, `rr_ptr`=0, state IDLE.
- Arbitration bubble: 1 cycle (IDLE→LOCK) before the first beat is accepted.
- Latency: an accepted beat appears on `cd_*` the next cycle. Throughput is 1 beat/cycle while unstalled.
- After the L beat is accepted, a minimum of 1 idle cycle occurs before the next packet's first beat is accepted.
- Stall: `cd_*` holds stable while `dc_sflags[0]`=1. Busy to the granted requester asserts in the same cycle, combinationally from `dc_sflags[0]`.
- Single-beat packet (F&L together): IDLE→LOCK→IDLE, 2 cycles per packet.
- Reset mid-packet: the output beat is dropped immediately (V=0) and the lock is released. Partial packets are not resumed.

## Structure
- Shared package `stream_pkg`:
  - flag bit positions `MF_A`=3, `MF_F`=2, `MF_L`=1, `MF_V`=0.
  - `SF_BUSY`=0.
  - typedef for the 4-bit mflags and 2-bit sflags.
  - FSM state enum {IDLE, LOCK}.
- Sub-module `rr_pick`: combinational round-robin first-one finder over an N-bit request vector from `rr_ptr`. Outputs valid and index. Reusable by other arbiters.

## Test plan
- Single requester 0, packet of 5 beats, d0=1..5, no stall → `cd_d0`=1..5 on consecutive cycles. First beat appears 2 cycles after the F beat is presented. `cd_tag`=0; F on beat 1, L on beat 5.
- Requesters 0..3 each present a 3-beat packet simultaneously → packets output in order tag 0,1,2,3. Each packet is contiguous, with 1 idle cycle between packets.
- `dc_sflags`=2'b01 for 4 cycles mid-packet → `cd_*` held constant. The granted requester's busy=1 for the same 4 cycles, and no beat is lost or duplicated.
- Requester 2 sends V without F (flags 4'b0001) while requester 1 is locked → requester 2's beat is consumed and `err_orphan` pulses once. Requester 1's output is unaffected.
- `cfg_en` cleared to 4'b1110 while requester 0 is mid-packet → requester 0's packet completes through L. Requester 0 is then never granted, while requesters 1..3 are.
- `rst_n` asserted at beat 3 of 5 → next cycle `cd_mflags`=0 and all busy=1. After release, a fresh packet from requester 3 is granted, because `rr_ptr` restarts at 0 and finds requester 3 as the only request.
